// File: rtl/mode_scheduler_if.sv
// Button, ring-request and display-mode signals shared between the mode scheduler
// and the mode wrappers it serves.
interface mode_scheduler_if #(
    parameter int NUM_MODES = 4
);
    logic                 real_tick;
    logic                 pulsed_mode;
    logic                 pulsed_set;
    logic                 pulsed_up;
    logic                 pulsed_down;
    logic [NUM_MODES-1:0] sub_busy;
    logic                 alarm_req;
    logic                 timer_req;
    logic [1:0]           currentMode;
    logic [NUM_MODES-1:0] set_out;
    logic [NUM_MODES-1:0] up_out;
    logic [NUM_MODES-1:0] down_out;
    logic                 ringing;
    logic                 buzzer;
    logic [1:0]           ring_ack;

    modport master (
        output real_tick, pulsed_mode, pulsed_set, pulsed_up, pulsed_down,
        output sub_busy, alarm_req, timer_req,
        input  currentMode, set_out, up_out, down_out, ringing, buzzer, ring_ack
    );

    modport slave (
        input  real_tick, pulsed_mode, pulsed_set, pulsed_up, pulsed_down,
        input  sub_busy, alarm_req, timer_req,
        output currentMode, set_out, up_out, down_out, ringing, buzzer, ring_ack
    );
endinterface

// File: rtl/mode_scheduler.sv
// Shares the buttons and display among clock/alarm/stopwatch/timer, routes button pulses
// to the active mode and lets alarm/timer expiry take over. Optional macro: AUTO_RETURN_EN.
module mode_scheduler #(
    parameter int NUM_MODES  = 4,
    parameter int RING_TICKS = 30,
    parameter int IDLE_TICKS = 20
) (
    input  logic              clk,
    input  logic              reset,
    mode_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_LOCKED = 2'd1,
        S_RING   = 2'd2
    } state_t;

    localparam int CNT_MAX = (RING_TICKS > IDLE_TICKS) ? RING_TICKS : IDLE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [1:0] ALARM_MODE = 2'd1;
    localparam logic [1:0] TIMER_MODE = 2'd3;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           saved_q, saved_d;
    logic                 pend_alarm_q, pend_alarm_d;
    logic                 pend_timer_q, pend_timer_d;
    logic                 serve_timer_q, serve_timer_d;
    logic [CNT_W-1:0]     ring_cnt_q, ring_cnt_d;
    logic                 phase_q, phase_d;
    logic [NUM_MODES-1:0] set_q, set_d;
    logic [NUM_MODES-1:0] up_q, up_d;
    logic [NUM_MODES-1:0] down_q, down_d;
    logic [1:0]           ack_q, ack_d;
`ifdef AUTO_RETURN_EN
    logic [CNT_W-1:0]     idle_q, idle_d;
`endif

    logic [NUM_MODES-1:0] mode_onehot;
    logic [1:0]           next_mode;
    logic                 any_btn;
    logic                 cur_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MODES; gi++) begin : g_route
            assign mode_onehot[gi] = (mode_q == 2'(gi));
        end
    endgenerate

    assign next_mode = (mode_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_q + 2'd1;
    assign any_btn   = bus.pulsed_mode | bus.pulsed_set | bus.pulsed_up | bus.pulsed_down;
    assign cur_busy  = bus.sub_busy[mode_q];

    always_comb begin
        logic eff_alarm;
        logic eff_timer;
        logic ack_now;
        logic other_pend;

        state_d       = state_q;
        mode_d        = mode_q;
        saved_d       = saved_q;
        pend_alarm_d  = pend_alarm_q;
        pend_timer_d  = pend_timer_q;
        serve_timer_d = serve_timer_q;
        ring_cnt_d    = ring_cnt_q;
        phase_d       = phase_q;
        set_d         = '0;
        up_d          = '0;
        down_d        = '0;
        ack_d         = 2'b00;
`ifdef AUTO_RETURN_EN
        idle_d        = '0;
`endif
        eff_alarm  = pend_alarm_q | bus.alarm_req;
        eff_timer  = pend_timer_q | bus.timer_req;
        ack_now    = 1'b0;
        other_pend = 1'b0;

        case (state_q)
            S_NORMAL, S_LOCKED: begin
                if (bus.pulsed_set)  set_d  = mode_onehot;
                if (bus.pulsed_up)   up_d   = mode_onehot;
                if (bus.pulsed_down) down_d = mode_onehot;

                if (eff_alarm || eff_timer) begin
                    // The served source's flag is dropped on entry, so a repeat
                    // request while it rings is simply absorbed.
                    state_d       = S_RING;
                    saved_d       = mode_q;
                    serve_timer_d = ~eff_alarm;
                    mode_d        = eff_alarm ? ALARM_MODE : TIMER_MODE;
                    pend_alarm_d  = 1'b0;
                    pend_timer_d  = eff_alarm & eff_timer;
                    ring_cnt_d    = '0;
                    phase_d       = 1'b1;
                end else begin
                    state_d = cur_busy ? S_LOCKED : S_NORMAL;
                    if (state_q == S_NORMAL && !cur_busy && bus.pulsed_mode) begin
                        mode_d = next_mode;
                    end
`ifdef AUTO_RETURN_EN
                    if (state_q == S_NORMAL && !cur_busy && mode_q != 2'd0 && !any_btn) begin
                        if (bus.real_tick) begin
                            if (idle_q == CNT_W'(IDLE_TICKS - 1)) begin
                                mode_d = 2'd0;
                            end else begin
                                idle_d = idle_q + 1'b1;
                            end
                        end else begin
                            idle_d = idle_q;
                        end
                    end
`endif
                end
            end

            S_RING: begin
                pend_alarm_d = pend_alarm_q | (bus.alarm_req & serve_timer_q);
                pend_timer_d = pend_timer_q | (bus.timer_req & ~serve_timer_q);
                ack_now = any_btn ||
                          (bus.real_tick && ring_cnt_q == CNT_W'(RING_TICKS - 1));

                if (ack_now) begin
                    ack_d      = serve_timer_q ? 2'b10 : 2'b01;
                    other_pend = serve_timer_q ? pend_alarm_d : pend_timer_d;
                    if (other_pend) begin
                        serve_timer_d = ~serve_timer_q;
                        mode_d        = serve_timer_q ? ALARM_MODE : TIMER_MODE;
                        if (serve_timer_q) pend_alarm_d = 1'b0;
                        else               pend_timer_d = 1'b0;
                        ring_cnt_d    = '0;
                        phase_d       = 1'b1;
                    end else begin
                        mode_d  = saved_q;
                        state_d = bus.sub_busy[saved_q] ? S_LOCKED : S_NORMAL;
                    end
                end else if (bus.real_tick) begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                    phase_d    = ~phase_q;
                end
            end

            default: state_d = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_NORMAL;
            mode_q        <= 2'd0;
            saved_q       <= 2'd0;
            pend_alarm_q  <= 1'b0;
            pend_timer_q  <= 1'b0;
            serve_timer_q <= 1'b0;
            ring_cnt_q    <= '0;
            phase_q       <= 1'b0;
            set_q         <= '0;
            up_q          <= '0;
            down_q        <= '0;
            ack_q         <= 2'b00;
`ifdef AUTO_RETURN_EN
            idle_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            saved_q       <= saved_d;
            pend_alarm_q  <= pend_alarm_d;
            pend_timer_q  <= pend_timer_d;
            serve_timer_q <= serve_timer_d;
            ring_cnt_q    <= ring_cnt_d;
            phase_q       <= phase_d;
            set_q         <= set_d;
            up_q          <= up_d;
            down_q        <= down_d;
            ack_q         <= ack_d;
`ifdef AUTO_RETURN_EN
            idle_q        <= idle_d;
`endif
        end
    end

    assign bus.currentMode = mode_q;
    assign bus.set_out     = set_q;
    assign bus.up_out      = up_q;
    assign bus.down_out    = down_q;
    assign bus.ringing     = (state_q == S_RING);
    assign bus.buzzer      = (state_q == S_RING) & phase_q;
    assign bus.ring_ack    = ack_q;

endmodule

// File: doc/mode_scheduler.md
Name: mode_scheduler

Overview:
- Top-level controller that shares the three debounced buttons and the six-digit display among the four time-keeping modes: 0 clock, 1 alarm, 2 stopwatch, 3 timer.
- Generates the currentMode bus consumed by the clock wrapper and its sibling mode wrappers.
- Forwards set/up/down pulses only to the active mode.
- Lets alarm/timer expiry pre-empt the display, and blocks mode changes while a sub-block is mid-edit.

Parameters:
- NUM_MODES, 4: number of selectable modes; currentMode wraps modulo this.
- RING_TICKS, 30: real_tick count after which an unacknowledged ring stops by itself.
- IDLE_TICKS, 20: real_tick count of button inactivity before auto-return to mode 0 (AUTO_RETURN_EN only).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- real_tick  input  1  1 Hz strobe, one clk wide, synchronous to clk.
- pulsed_mode  input  1  one-cycle mode-button pulse.
- pulsed_set  input  1  one-cycle set-button pulse.
- pulsed_up  input  1  one-cycle up-button pulse.
- pulsed_down  input  1  one-cycle down-button pulse.
- sub_busy  input  NUM_MODES  bit i high while mode i's sub-block is in a non-zero (edit) state.
- alarm_req  input  1  one-cycle alarm-match pulse.
- timer_req  input  1  one-cycle timer-expiry pulse.
- currentMode  output  2  active mode index.
- set_out  output  NUM_MODES  set pulse routed one-hot to the active mode.
- up_out  output  NUM_MODES  up pulse routed one-hot to the active mode.
- down_out  output  NUM_MODES  down pulse routed one-hot to the active mode.
- ringing  output  1  high while in RING.
- buzzer  output  1  ringing gated by a 1 Hz toggle.
- ring_ack  output  2  one-cycle acknowledge: bit0 = alarm, bit1 = timer.

Behaviour:
- Reset (reset==0, asynchronous) → all outputs 0:
  - state NORMAL, currentMode 0.
  - pending flags, saved mode, tick counters and blink phase all cleared.
- All outputs are registered. A button pulse in cycle N appears on the routed output in cycle N+1, for exactly one cycle.

State NORMAL:
- pulsed_mode with sub_busy[currentMode]==0 → currentMode <= (currentMode+1) mod NUM_MODES. The mode pulse is never forwarded.
- set/up/down → the corresponding bit [currentMode] of set_out/up_out/down_out.
- sub_busy[currentMode]==1 → LOCKED, on the next cycle.

State LOCKED:
- pulsed_mode is ignored.
- Buttons are routed as in NORMAL.
- sub_busy[currentMode]==0 → NORMAL.

Ring requests:
- alarm_req / timer_req set pend_alarm / pend_timer in any state.
- From NORMAL or LOCKED, any pending flag set → RING on the next cycle:
  - saved_mode <= currentMode.
  - currentMode <= 1 if serving alarm, 3 if serving timer; alarm wins when both are pending.
  - ring counter cleared.
- Ring requests override a same-cycle pulsed_mode.

State RING:
- ringing=1. buzzer = blink phase, toggled on each real_tick and starting at 1.
- Nothing is forwarded on set_out/up_out/down_out. pulsed_mode is ignored.
- Any of set/up/down/mode pulses → ACK:
  - ring_ack bit of the served source = 1 for one cycle, and its pend flag is cleared.
- Ring counter reaches RING_TICKS → ACK, same actions, without a button.
- After ACK:
  - If the other pend flag is set, serve it next: RING again, saved_mode is kept, counter restarts.
  - Otherwise currentMode <= saved_mode; state becomes LOCKED if sub_busy[saved_mode], else NORMAL.
- A request for the source currently being served is absorbed (the pend flag stays clear).

Simultaneous events and edge cases:
- alarm_req and timer_req in the same cycle → both pend; alarm is served first.
- A button pulse and a ring request in the same cycle → the pulse is forwarded (not in RING), then RING is entered.
- Reset mid-RING → immediate return to mode 0 with no ring_ack.
- real_tick coinciding with a button pulse in RING → the ack takes priority; the counter is not incremented.

Optional Feature:
- Macro AUTO_RETURN_EN.
- Defined:
  - An idle counter counts real_tick while in NORMAL with currentMode≠0.
  - It clears on any button pulse, on a mode change, or on leaving NORMAL.
  - Reaching IDLE_TICKS → currentMode <= 0 on the next cycle, counter cleared.
  - Never fires in LOCKED or RING.
- Undefined: no idle counter; currentMode changes only by pulsed_mode or ring handling. IDLE_TICKS is unused.

Test Plan:
- Reset low, then high; four pulsed_mode pulses → currentMode 1,2,3,0, each one cycle after its pulse; all routed outputs stay 0.
- currentMode=2, pulsed_up → up_out=4'b0100 for exactly one cycle, one cycle later.
- currentMode=0, sub_busy=4'b0001 → LOCKED; pulsed_mode ignored and currentMode stays 0; pulsed_set still gives set_out=4'b0001; sub_busy=0, then pulsed_mode → currentMode 1.
- currentMode=2, alarm_req and timer_req in the same cycle:
  - currentMode 1, ringing=1.
  - pulsed_down → ring_ack=2'b01, down_out stays 0, currentMode 3.
  - 30 real_ticks with no press → ring_ack=2'b10, currentMode 2, ringing=0.
- In RING, reset asserted → currentMode 0, ringing 0, ring_ack 0 immediately.
- AUTO_RETURN_EN defined, currentMode=3, 20 real_ticks with no press → currentMode 0. A pulsed_up at tick 19 restarts the count.
